// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its neighbours: CPU request port,
// DMA request port and the single memory port.
//   cpu_*  : CPU memory-stage request/ack/read data/stall
//   dma_*  : DMA/loader request/ack/read data
//   mem_*  : single-port memory (combinational read)
//   owner_o: current bus owner (00 idle, 01 CPU, 10 DMA)
// slave  : arbiter side; master : requesters + memory side.
interface data_mem_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();
   logic          cpu_req_i;
   logic          cpu_we_i;
   logic [AW-1:0] cpu_addr_i;
   logic [DW-1:0] cpu_wdata_i;
   logic          cpu_ack_o;
   logic [DW-1:0] cpu_rdata_o;
   logic          cpu_stall_o;

   logic          dma_req_i;
   logic          dma_we_i;
   logic [AW-1:0] dma_addr_i;
   logic [DW-1:0] dma_wdata_i;
   logic          dma_ack_o;
   logic [DW-1:0] dma_rdata_o;

   logic          mem_ce_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;

   logic [1:0]    owner_o;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      output cpu_ack_o, cpu_rdata_o, cpu_stall_o,
      input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
      output dma_ack_o, dma_rdata_o,
      output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i,
      output owner_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      input  cpu_ack_o, cpu_rdata_o, cpu_stall_o,
      output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
      input  dma_ack_o, dma_rdata_o,
      input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i,
      input  owner_o
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter (CPU first, DMA second) for the single-port data memory.
// Bounded run lengths under contention keep either side from starving; each
// hand-over costs one dead cycle. Outputs are combinational from state and
// requests and are all forced low while rst is asserted.
//   clk : clock
//   rst : synchronous reset, active-low
//   bus : data_mem_arbiter_if.slave (CPU port, DMA port, memory port, owner)
module data_mem_arbiter #(
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32,
   parameter int unsigned CPU_MAX_RUN = 4,
   parameter int unsigned DMA_MAX_RUN = 2
) (
   input  logic              clk,
   input  logic              rst,
   data_mem_arbiter_if.slave bus
);

   localparam int unsigned MAX_RUN = (CPU_MAX_RUN > DMA_MAX_RUN) ? CPU_MAX_RUN : DMA_MAX_RUN;
   localparam int unsigned RW      = $clog2(MAX_RUN) + 1;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_CPU  = 2'b01;
   localparam logic [1:0] S_DMA  = 2'b10;

   localparam logic [RW-1:0] CPU_LIM = RW'(CPU_MAX_RUN);
   localparam logic [RW-1:0] DMA_LIM = RW'(DMA_MAX_RUN);

   logic [1:0]    state_q, state_d;
   logic [RW-1:0] run_cnt_q, run_cnt_d;
   logic          cpu_go, dma_go;

   // State and run counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         run_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   // Next state, issue decision and bus outputs
   always_comb begin
      state_d   = state_q;
      run_cnt_d = '0;
      cpu_go    = 1'b0;
      dma_go    = 1'b0;

      unique case (state_q)
         // Once the run limit is reached under contention the owner issues
         // nothing this cycle and hands over: this is the dead switch cycle.
         S_CPU: begin
            if (bus.dma_req_i) begin
               if (bus.cpu_req_i && (run_cnt_q != CPU_LIM)) begin
                  cpu_go    = 1'b1;
                  run_cnt_d = run_cnt_q + RW'(1);
               end else begin
                  state_d = S_DMA;
               end
            end else begin
               cpu_go = bus.cpu_req_i;
            end
         end
         S_DMA: begin
            if (bus.cpu_req_i) begin
               if (bus.dma_req_i && (run_cnt_q != DMA_LIM)) begin
                  dma_go    = 1'b1;
                  run_cnt_d = run_cnt_q + RW'(1);
               end else begin
                  state_d = S_CPU;
               end
            end else begin
               dma_go = bus.dma_req_i;
            end
         end
         default: begin
            if (bus.cpu_req_i) begin
               state_d = S_CPU;
            end else if (bus.dma_req_i) begin
               state_d = S_DMA;
            end
         end
      endcase

      bus.cpu_ack_o   = 1'b0;
      bus.cpu_rdata_o = DW'(0);
      bus.cpu_stall_o = 1'b0;
      bus.dma_ack_o   = 1'b0;
      bus.dma_rdata_o = DW'(0);
      bus.mem_ce_o    = 1'b0;
      bus.mem_we_o    = 1'b0;
      bus.mem_addr_o  = AW'(0);
      bus.mem_wdata_o = DW'(0);
      bus.owner_o     = 2'b00;

      if (rst) begin
         bus.owner_o     = state_q;
         bus.cpu_stall_o = bus.cpu_req_i & ~cpu_go;
         if (cpu_go) begin
            bus.cpu_ack_o   = 1'b1;
            bus.cpu_rdata_o = bus.mem_rdata_i;
            bus.mem_ce_o    = 1'b1;
            bus.mem_we_o    = bus.cpu_we_i;
            bus.mem_addr_o  = bus.cpu_addr_i;
            bus.mem_wdata_o = bus.cpu_wdata_i;
         end else if (dma_go) begin
            bus.dma_ack_o   = 1'b1;
            bus.dma_rdata_o = bus.mem_rdata_i;
            bus.mem_ce_o    = 1'b1;
            bus.mem_we_o    = bus.dma_we_i;
            bus.mem_addr_o  = bus.dma_addr_i;
            bus.mem_wdata_o = bus.dma_wdata_i;
         end
      end
   end

endmodule
